// File: rtl/core_reg_bank.sv
// Mode-banked ARM register file: 30 physical entries behind per-mode r0-r14 mapping, r15 redirected to PC / branch.
// Optional write-through on same-index read/write: define CORE_REG_BYPASS_EN.
module core_reg_bank #(
    parameter int WIDTH    = 32,
    parameter int RD_PORTS = 2,
    parameter int CLEAR    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                mode,
    input  logic [RD_PORTS*4-1:0]     rd_r,
    input  logic [RD_PORTS-1:0]       rd_usr,
    output logic [RD_PORTS*WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0]          pc_visible,
    input  logic                      wr_en,
    input  logic [3:0]                wr_r,
    input  logic                      wr_usr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      branch,
    output logic [WIDTH-1:0]          branch_tgt,
    output logic                      ready
);

    // state  | meaning
    // ST_CLR | post-reset sweep zeroing entry cnt_q, ready=0 (entered from reset when CLEAR)
    // ST_RUN | normal operation, ready=1 (entered from reset when !CLEAR)
    typedef enum logic {ST_CLR, ST_RUN} state_t;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;
    localparam state_t     ST_RST = (CLEAR != 0) ? ST_CLR : ST_RUN;

    // Returns {legal, physical index}; banked registers sit above the 15 USR entries.
    function automatic logic [5:0] map_reg(input logic [3:0] r, input logic [4:0] m);
        logic [4:0] r5;
        r5 = {1'b0, r};
        case (m)
            M_USR, M_SYS: map_reg = {1'b1, r5};
            M_FIQ:        map_reg = {1'b1, (r >= 4'd8)  ? r5 + 5'd7  : r5};
            M_IRQ:        map_reg = {1'b1, (r >= 4'd13) ? r5 + 5'd9  : r5};
            M_UND:        map_reg = {1'b1, (r >= 4'd13) ? r5 + 5'd11 : r5};
            M_ABT:        map_reg = {1'b1, (r >= 4'd13) ? r5 + 5'd13 : r5};
            M_SVC:        map_reg = {1'b1, (r >= 4'd13) ? r5 + 5'd15 : r5};
            default:      map_reg = 6'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             branch_q, branch_d;
    logic [WIDTH-1:0] branch_tgt_q, branch_tgt_d;
    logic [WIDTH-1:0] mem_q [0:29];

    logic [5:0]       wr_map;
    logic             wr_do;

    assign ready      = (state_q == ST_RUN);
    assign branch     = branch_q;
    assign branch_tgt = branch_tgt_q;

    always_comb begin
        wr_map       = map_reg(wr_r, wr_usr ? M_USR : mode);
        wr_do        = wr_en && ready && (wr_r != 4'd15) && wr_map[5];
        branch_d     = wr_en && ready && (wr_r == 4'd15);
        branch_tgt_d = branch_d ? wr_data : branch_tgt_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (state_q == ST_CLR) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd29) begin
                state_d = ST_RUN;
                cnt_d   = 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            cnt_q        <= 5'd0;
            branch_q     <= 1'b0;
            branch_tgt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            branch_q     <= branch_d;
            branch_tgt_q <= branch_tgt_d;
        end
    end

    // Storage has no reset so it can map onto a RAM; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_do) begin
            mem_q[wr_map[4:0]] <= wr_data;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [3:0]       r;
        logic [5:0]       map;
        logic [WIDTH-1:0] val;

        always_comb begin
            r   = rd_r[4*k +: 4];
            map = map_reg(r, rd_usr[k] ? M_USR : mode);
            val = '0;
            if (r == 4'd15) begin
                val = pc_visible;
            end else if (map[5]) begin
`ifdef CORE_REG_BYPASS_EN
                if (wr_do && (wr_map[4:0] == map[4:0])) begin
                    val = wr_data;
                end else begin
                    val = mem_q[map[4:0]];
                end
`else
                val = mem_q[map[4:0]];
`endif
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = val;
    end

endmodule

// File: tb/tb_core_reg_bank.sv
// Directed self-checking bench for core_reg_bank (WIDTH=32, RD_PORTS=2, CLEAR=1).
module tb_core_reg_bank;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mode;
    logic [7:0]  rd_r;
    logic [1:0]  rd_usr;
    logic [63:0] rd_data;
    logic [31:0] pc_visible;
    logic        wr_en;
    logic [3:0]  wr_r;
    logic        wr_usr;
    logic [31:0] wr_data;
    logic        branch;
    logic [31:0] branch_tgt;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    core_reg_bank #(.WIDTH(32), .RD_PORTS(2), .CLEAR(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .rd_r       (rd_r),
        .rd_usr     (rd_usr),
        .rd_data    (rd_data),
        .pc_visible (pc_visible),
        .wr_en      (wr_en),
        .wr_r       (wr_r),
        .wr_usr     (wr_usr),
        .wr_data    (wr_data),
        .branch     (branch),
        .branch_tgt (branch_tgt),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] m, input logic [3:0] r0, input logic usr0,
                      input logic [3:0] r1, input logic usr1);
        mode   = m;
        rd_r   = {r1, r0};
        rd_usr = {usr1, usr0};
        #1;
    endtask

    task automatic wr(input logic [4:0] m, input logic [3:0] r, input logic usr, input logic [31:0] d);
        mode    = m;
        wr_en   = 1'b1;
        wr_r    = r;
        wr_usr  = usr;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_usr  = 1'b0;
    endtask

    initial begin
        logic [4:0] modes [7];
        int n;
        modes = '{M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS};

        rst_n = 1'b0; mode = M_USR; rd_r = 8'h0; rd_usr = 2'b00; pc_visible = 32'h1234;
        wr_en = 1'b0; wr_r = 4'd0; wr_usr = 1'b0; wr_data = 32'h0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_branch", {31'd0, branch}, 32'd0);
        check("rst_tgt", branch_tgt, 32'd0);

        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("sweep_len", n, 30);

        for (int mi = 0; mi < 7; mi++) begin
            for (int r = 0; r < 15; r += 2) begin
                rd(modes[mi], 4'(r), 1'b0, 4'((r + 1) % 15), 1'b0);
                check("clr_p0", rd_data[31:0], 32'd0);
                check("clr_p1", rd_data[63:32], 32'd0);
            end
        end

        wr(M_USR, 4'd13, 1'b0, 32'h1111);
        wr(M_SVC, 4'd13, 1'b0, 32'h2222);
        rd(M_USR, 4'd13, 1'b0, 4'd13, 1'b0);
        check("usr_r13", rd_data[31:0], 32'h1111);
        rd(M_SVC, 4'd13, 1'b0, 4'd13, 1'b1);
        check("svc_r13", rd_data[31:0], 32'h2222);
        check("svc_r13_usr", rd_data[63:32], 32'h1111);
        rd(M_IRQ, 4'd13, 1'b0, 4'd14, 1'b0);
        check("irq_r13", rd_data[31:0], 32'd0);
        rd(M_SYS, 4'd13, 1'b0, 4'd13, 1'b0);
        check("sys_r13", rd_data[31:0], 32'h1111);

        wr(M_FIQ, 4'd8, 1'b0, 32'hA5A5A5A5);
        rd(M_USR, 4'd8, 1'b0, 4'd8, 1'b0);
        check("usr_r8", rd_data[31:0], 32'd0);
        rd(M_FIQ, 4'd8, 1'b0, 4'd8, 1'b1);
        check("fiq_r8", rd_data[31:0], 32'hA5A5A5A5);
        check("fiq_r8_usr", rd_data[63:32], 32'd0);
        wr(M_FIQ, 4'd8, 1'b1, 32'd7);
        rd(M_USR, 4'd8, 1'b0, 4'd8, 1'b0);
        check("usr_r8_wusr", rd_data[31:0], 32'd7);
        rd(M_FIQ, 4'd8, 1'b0, 4'd7, 1'b0);
        check("fiq_r8_kept", rd_data[31:0], 32'hA5A5A5A5);

        wr(5'b00000, 4'd0, 1'b0, 32'h99);
        rd(M_USR, 4'd0, 1'b0, 4'd0, 1'b0);
        check("bad_mode_wr", rd_data[31:0], 32'd0);
        rd(5'b00000, 4'd13, 1'b0, 4'd13, 1'b1);
        check("bad_mode_rd", rd_data[31:0], 32'd0);
        check("bad_mode_rd_usr", rd_data[63:32], 32'h1111);

        rd(M_USR, 4'd15, 1'b0, 4'd15, 1'b0);
        check("r15_rd", rd_data[31:0], 32'h1234);
        check("pre_branch", {31'd0, branch}, 32'd0);
        wr(M_USR, 4'd15, 1'b0, 32'h8000);
        check("branch_1", {31'd0, branch}, 32'd1);
        check("branch_tgt", branch_tgt, 32'h8000);
        check("r15_rd_b", rd_data[63:32], 32'h1234);
        tick();
        check("branch_0", {31'd0, branch}, 32'd0);
        check("r15_rd_c", rd_data[31:0], 32'h1234);
        mode = M_USR; wr_en = 1'b1; wr_r = 4'd15; wr_data = 32'h100;
        tick();
        check("b2b_1", {31'd0, branch}, 32'd1);
        check("b2b_1_tgt", branch_tgt, 32'h100);
        wr_data = 32'h200;
        tick();
        wr_en = 1'b0;
        check("b2b_2", {31'd0, branch}, 32'd1);
        check("b2b_2_tgt", branch_tgt, 32'h200);
        tick();
        check("b2b_end", {31'd0, branch}, 32'd0);

        mode = M_USR; wr_en = 1'b1; wr_r = 4'd3; wr_data = 32'h55;
        rd_r = {4'd0, 4'd3}; rd_usr = 2'b00;
        #1;
`ifdef CORE_REG_BYPASS_EN
        check("same_cyc_r3", rd_data[31:0], 32'h55);
`else
        check("same_cyc_r3", rd_data[31:0], 32'd0);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("next_cyc_r3", rd_data[31:0], 32'h55);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_sweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            mode    = M_USR;
            wr_en   = 1'b1;
            wr_r    = (n < 15) ? 4'd5 : 4'd15;
            wr_data = 32'hDEAD;
            tick();
            n++;
            if (branch) check("sweep_branch", {31'd0, branch}, 32'd0);
        end
        wr_en = 1'b0;
        check("resweep_len", n, 30);
        check("resweep_branch", {31'd0, branch}, 32'd0);
        rd(M_USR, 4'd5, 1'b0, 4'd13, 1'b0);
        check("resweep_r5", rd_data[31:0], 32'd0);
        check("resweep_r13", rd_data[63:32], 32'd0);
        rd(M_SVC, 4'd13, 1'b0, 4'd3, 1'b0);
        check("resweep_svc", rd_data[31:0], 32'd0);
        check("resweep_r3", rd_data[63:32], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
